exec_unit: RTL

Execute stage of the 19-bit CPU. It sits directly downstream of the register file and consumes its two read ports (RD1/RD2), which the decoder latches into this block together with an opcode and a destination index. It then drives the register file's write port (wE3/A3/wD3). Single-cycle logic ops are fully pipelined; multiply, divide and modulo run as 19-iteration multi-cycle sequences behind a valid/ready handshake.

---
 rtl/exec_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 19-bit CPU, driving the register-file write port (wE3/A3/wD3).
// Optional macro EXEC_MULDIV_EN builds the iterative MUL/DIV/MOD datapath; without it ops 8-10 are illegal.
module exec_unit #(
  parameter int WIDTH = 19,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    dst,
  output logic             wE3,
  output logic [AW-1:0]    A3,
  output logic [WIDTH-1:0] wD3,
  output logic             busy,
  output logic             zero_f,
  output logic             carry_f,
  output logic             illegal_op
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [WIDTH:0] One = (WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, WB} state_t;

  state_t           state_q;
  logic             wE3_q;
  logic [AW-1:0]    A3_q;
  logic [WIDTH-1:0] wD3_q;
  logic             zero_q;
  logic             carry_q;
  logic             illegal_q;

  logic [WIDTH:0]   aluSum;
  logic [WIDTH-1:0] aluRes;
  logic             aluCarry;
  logic             opIllegal;

  // Single-cycle ALU; the extra sum bit is carry for ADD/INC and borrow for SUB/DEC.
  always_comb begin
    aluSum   = '0;
    aluRes   = '0;
    aluCarry = 1'b0;
    case (op)
      4'd0: begin
        aluSum   = {1'b0, rd1} + {1'b0, rd2};
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      4'd1: begin
        aluSum   = {1'b0, rd1} - {1'b0, rd2};
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      4'd2: aluRes = rd1 & rd2;
      4'd3: aluRes = rd1 | rd2;
      4'd4: aluRes = rd1 ^ rd2;
      4'd5: aluRes = ~rd1;
      4'd6: begin
        aluSum   = {1'b0, rd1} + One;
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      4'd7: begin
        aluSum   = {1'b0, rd1} - One;
        aluRes   = aluSum[WIDTH-1:0];
        aluCarry = aluSum[WIDTH];
      end
      default: ;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  assign opIllegal = (op > 4'd10);

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic [WIDTH-1:0] acc_q;
  logic             isMod_q;
  logic [AW-1:0]    dst_q;

  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH:0]   divTrial;
  logic [WIDTH-1:0] divDiff;
  logic             divGe;
  logic [WIDTH-1:0] divRem;
  logic [WIDTH-1:0] divQuo;
  logic [WIDTH-1:0] mdRes;

  // MUL: opA shifts the multiplier right, opB the multiplicand left, acc holds the partial product.
  // DIV: opA shifts the dividend out and the quotient in, acc holds the partial remainder.
  assign mulAcc   = acc_q + (opA_q[0] ? opB_q : '0);
  assign divTrial = {acc_q, opA_q[WIDTH-1]};
  assign divGe    = (divTrial >= {1'b0, opB_q});
  assign divDiff  = divTrial[WIDTH-1:0] - opB_q;
  assign divRem   = divGe ? divDiff : divTrial[WIDTH-1:0];
  assign divQuo   = {opA_q[WIDTH-2:0], divGe};
  assign mdRes    = (state_q == MUL) ? mulAcc : (isMod_q ? divRem : divQuo);
  assign busy     = (state_q != IDLE);
`else
  assign opIllegal = (op > 4'd7);
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wE3_q     <= 1'b0;
      A3_q      <= '0;
      wD3_q     <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_MULDIV_EN
      cnt_q     <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      acc_q     <= '0;
      isMod_q   <= 1'b0;
      dst_q     <= '0;
`endif
    end else begin
      wE3_q     <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (opIllegal) begin
              illegal_q <= 1'b1;
            end
`ifdef EXEC_MULDIV_EN
            else if (op >= 4'd8) begin
              state_q <= (op == 4'd8) ? MUL : DIV;
              cnt_q   <= '0;
              acc_q   <= '0;
              isMod_q <= (op == 4'd10);
              dst_q   <= dst;
              opA_q   <= (op == 4'd8) ? rd2 : rd1;
              opB_q   <= (op == 4'd8) ? rd1 : rd2;
            end
`endif
            else begin
              wE3_q   <= (dst != '0);
              A3_q    <= dst;
              wD3_q   <= aluRes;
              zero_q  <= (aluRes == '0);
              carry_q <= aluCarry;
            end
          end
        end
`ifdef EXEC_MULDIV_EN
        MUL, DIV: begin
          cnt_q <= cnt_q + CntW'(1);
          if (state_q == MUL) begin
            acc_q <= mulAcc;
            opA_q <= opA_q >> 1;
            opB_q <= opB_q << 1;
          end else begin
            acc_q <= divRem;
            opA_q <= divQuo;
          end
          // The last iteration's combinational result goes straight into the write-port registers.
          if (cnt_q == CntW'(WIDTH-1)) begin
            state_q <= WB;
            wE3_q   <= (dst_q != '0);
            A3_q    <= dst_q;
            wD3_q   <= mdRes;
            zero_q  <= (mdRes == '0);
            carry_q <= 1'b0;
          end
        end
        WB: state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign wE3        = wE3_q;
  assign A3         = A3_q;
  assign wD3        = wD3_q;
  assign zero_f     = zero_q;
  assign carry_f    = carry_q;
  assign illegal_op = illegal_q;

endmodule
